// File: rtl/unpacker_if.sv
// -----------------------------------------------------------------------------
// unpacker_if
//
// Ready/valid bus for the unpacker. Holds both sides of the block: the packed
// input stream from upstream and the symbol output stream to downstream.
//
// Signals (names are from the unpacker's point of view):
//   packed_i    packed word from upstream
//   valid_i     packed_i is valid
//   ready_o     unpacker can accept packed_i this cycle
//   unpacked_o  current symbol
//   valid_o     unpacked_o is valid
//   ready_i     downstream accepts unpacked_o
//   index_o     position (0..N-1) of the current symbol within its word
//
// Modports:
//   slave   the unpacker itself
//   master  the environment (upstream source plus downstream sink)
// -----------------------------------------------------------------------------
interface unpacker_if #(
    parameter int packed_width_p = 8,
    parameter int symbol_width_p = 2
);

    localparam int n_lp           = packed_width_p / symbol_width_p;
    localparam int index_width_lp = $clog2(n_lp);

    logic [packed_width_p-1:0] packed_i;
    logic                      valid_i;
    logic                      ready_o;
    logic [symbol_width_p-1:0] unpacked_o;
    logic                      valid_o;
    logic                      ready_i;
    logic [index_width_lp-1:0] index_o;

    modport slave (
        input  packed_i,
        input  valid_i,
        input  ready_i,
        output ready_o,
        output unpacked_o,
        output valid_o,
        output index_o
    );

    modport master (
        output packed_i,
        output valid_i,
        output ready_i,
        input  ready_o,
        input  unpacked_o,
        input  valid_o,
        input  index_o
    );

endinterface

// File: rtl/unpacker.sv
// -----------------------------------------------------------------------------
// unpacker
//
// Splits each packed word into N = packed_width_p / symbol_width_p symbols and
// emits them one per cycle on a ready/valid stream. Inverse of the symbol
// packer on the capture path, so packer -> unpacker is the identity. A new
// word is accepted in the same cycle the final symbol of the previous word
// leaves, giving one symbol per cycle with no bubbles across word boundaries.
//
// Parameters:
//   packed_width_p  input word width (default 8)
//   symbol_width_p  output symbol width, must divide packed_width_p (default 2)
//
// Ports:
//   clk_i     clock, rising edge
//   reset_ni  asynchronous active-low reset
//   bus       unpacker_if.slave: packed_i/valid_i/ready_o input stream,
//             unpacked_o/valid_o/ready_i/index_o output stream
//
// Build option:
//   UNPACKER_MSB_FIRST_EN  when defined, symbol 0 is the most significant
//                          symbol of the word; otherwise symbol 0 is the least
//                          significant one. index_o always counts in emission
//                          order.
// -----------------------------------------------------------------------------
module unpacker #(
    parameter int packed_width_p = 8,
    parameter int symbol_width_p = 2
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    unpacker_if.slave  bus
);

    localparam int n_lp           = packed_width_p / symbol_width_p;
    localparam int index_width_lp = $clog2(n_lp);
    localparam logic [index_width_lp-1:0] last_index_lp = index_width_lp'(n_lp - 1);

    logic [packed_width_p-1:0] data_r,  data_d;
    logic [index_width_lp-1:0] index_r, index_d;
    logic                      full_r,  full_d;

    logic                      last;
    logic                      in_fire;
    logic                      out_fire;
    logic                      ready;
    logic [index_width_lp-1:0] lane;
    logic [symbol_width_p-1:0] symbol;

    // Handshake. ready depends combinationally on ready_i so the word can be
    // replaced in the cycle its final symbol is taken.
    assign last     = (index_r == last_index_lp);
    assign ready    = !full_r || (last && bus.ready_i);
    assign in_fire  = bus.valid_i && ready;
    assign out_fire = full_r && bus.ready_i;

    // Map the emission index onto a physical lane of the stored word.
`ifdef UNPACKER_MSB_FIRST_EN
    assign lane = last_index_lp - index_r;
`else
    assign lane = index_r;
`endif

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        symbol = '0;
        for (int i = 0; i < n_lp; i++) begin
            if (lane == index_width_lp'(i)) begin
                symbol = data_r[i*symbol_width_p +: symbol_width_p];
            end
        end
    end

    // Next-state logic, highest priority first. An accept also covers the
    // case where the final symbol leaves in the same cycle.
    always_comb begin
        data_d  = data_r;
        index_d = index_r;
        full_d  = full_r;
        if (in_fire) begin
            data_d  = bus.packed_i;
            index_d = '0;
            full_d  = 1'b1;
        end else if (out_fire && !last) begin
            index_d = index_r + index_width_lp'(1);
        end else if (out_fire && last) begin
            // Clearing data keeps unpacked_o at zero while idle.
            data_d  = '0;
            index_d = '0;
            full_d  = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            // NOTE: the word register is reset too; it is a single word, and
            // a known zero is what the idle output must show.
            data_r  <= '0;
            index_r <= '0;
            full_r  <= 1'b0;
        end else begin
            data_r  <= data_d;
            index_r <= index_d;
            full_r  <= full_d;
        end
    end

    assign bus.ready_o    = ready;
    assign bus.valid_o    = full_r;
    assign bus.unpacked_o = symbol;
    assign bus.index_o    = index_r;

endmodule

// File: doc/unpacker.md
# unpacker

Splits each 8-bit packed byte into four 2-bit symbols and emits them one per cycle on a ready/valid stream. It is the inverse of the 2-bit-to-byte packer on the capture path, used where packed bytes (e.g. from the host/ESP link or frame memory) must be restored to 2-bit pixel symbols for downstream processing. Full throughput: with a continuous input stream and an always-ready sink, it emits one symbol every cycle with no bubbles between bytes.

## Interface

- `packed_width_p`, default 8: width of the input word.
- `symbol_width_p`, default 2: width of each output symbol. It must divide `packed_width_p`. Symbols per word N = `packed_width_p / symbol_width_p` (default 4); N ≥ 2.
- `clk_i`, input, 1: clock. All state changes on the rising edge.
- `reset_ni`, input, 1: asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronous to `clk_i` (handled upstream).
- `packed_i`, input, `packed_width_p`: packed word from upstream.
- `valid_i`, input, 1: `packed_i` is valid.
- `ready_o`, output, 1: block can accept `packed_i` this cycle.
- `unpacked_o`, output, `symbol_width_p`: current symbol.
- `valid_o`, output, 1: `unpacked_o` is valid.
- `ready_i`, input, 1: downstream accepts `unpacked_o`.
- `index_o`, output, $clog2(N): index (0..N-1) of the symbol currently on `unpacked_o`.

## Operation

- State registers:
  - `data_r` (`packed_width_p` bits) holds the word.
  - `index_r` (0..N-1) selects the symbol.
  - `full_r` marks that `data_r` holds undelivered symbols.
- Fire definitions:
  - in_fire = `valid_i && ready_o`.
  - out_fire = `valid_o && ready_i`.
  - last = (`index_r` == N-1).
- Outputs:
  - `valid_o` = `full_r`.
  - `ready_o` = `!full_r || (last && ready_i)`. This is combinational from `ready_i`, so the word can be replaced in the same cycle its final symbol leaves.
  - `unpacked_o` = `data_r[index_r*symbol_width_p +: symbol_width_p]`.
  - `index_o` = `index_r`.
- Default symbol order is LSB first: symbol 0 = `packed_i[1:0]`, symbol 3 = `packed_i[7:6]`. This matches the packer's bit placement, so packer→unpacker is identity.
- Per-cycle update, in priority order:
  1. in_fire: `data_r` ← `packed_i`, `index_r` ← 0, `full_r` ← 1. With `ready_o` as defined, this case covers simultaneous final out_fire plus in_fire.
  2. out_fire and not last: `index_r` ← `index_r` + 1.
  3. out_fire and last (no in_fire): `full_r` ← 0, `index_r` ← 0, `data_r` ← 0.
  4. Otherwise hold. While `valid_o && !ready_i`, `unpacked_o` and `index_o` are stable.
- `index_r` never exceeds N-1. It wraps to 0 only via rules 1 or 3.
- Whenever `valid_o` = 0, `unpacked_o` = 0 and `index_o` = 0.

## Timing

- Reset values: `valid_o` = 0, `ready_o` = 1, `unpacked_o` = 0, `index_o` = 0. All internal registers clear.
- Latency: a word accepted on edge k has symbol 0 valid in the cycle after edge k.
- Throughput: N symbols per word, 1 symbol/cycle sustained across word boundaries when `valid_i` and `ready_i` are held high.
- Input acceptance: one word per N cycles at best. `ready_o` is low while symbols 0..N-2 are pending.
- Reset asserted mid-word discards remaining symbols immediately. The first cycle after release shows `valid_o` = 0 and `ready_o` = 1.
- Rule for the upstream source: `valid_i` must not be withdrawn before in_fire once asserted. The block itself does not depend on this.

## Configuration

- `UNPACKER_MSB_FIRST_EN`
  - Defined: symbol order is reversed. Symbol 0 = `packed_i[packed_width_p-1 -: symbol_width_p]`, i.e. `packed_i[7:6]` for defaults, and the last symbol = `packed_i[1:0]`. `index_o` still counts 0..N-1 in emission order.
  - Undefined (default): LSB-first order as above.
  - Handshake, latency and throughput are identical in both builds.

## Test plan

- **Reset:** hold `reset_ni` = 0 and drive `valid_i` = 1 with `packed_i` = 8'hFF. Expect `valid_o` = 0, `ready_o` = 1 and `unpacked_o` = 0, with nothing accepted.
- **Single word:** send 8'b11_10_01_00 with `ready_i` = 1. Expect `unpacked_o` = 0,1,2,3 on 4 consecutive cycles starting 1 cycle after accept, `index_o` = 0..3, then `valid_o` = 0. With `UNPACKER_MSB_FIRST_EN`, expect 3,2,1,0.
- **Back-to-back:** stream 8'hE4, 8'h1B, 8'hFF with `valid_i` and `ready_i` always 1. Expect 12 symbols (0,1,2,3, 3,2,1,0, 3,3,3,3) on 12 consecutive cycles with no bubble. `ready_o` is high only on the cycles with `index_o` = 3, plus the initial cycle.
- **Backpressure:** send 8'hE4 and drop `ready_i` for 3 cycles while `index_o` = 1. `unpacked_o` must stay 1 and `index_o` must stay 1. After release, output 2,3 with no loss or duplication.
- **Reset mid-word:** accept 8'hE4, consume 2 symbols, then pulse `reset_ni` low asynchronously between edges. `valid_o` must fall immediately. The next word, 8'h1B, must then emit 3,2,1,0 cleanly.
- **Random loopback:** connect the packer output to the unpacker input with random valid/ready toggling over 10k symbols. The output symbol sequence must equal the packer's input sequence.
